mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL expose port Clk, input, 1 bit: single pipeline clock; all state changes on its rising edge.
REQ-002 The block SHALL expose port Rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The block SHALL expose inputs MEM_MemRead and MEM_MemWrite, 1 bit each: load/store request from the EX/MEM register.
REQ-004 The block SHALL expose input MEM_Datatype, 1 bit: 0 = word access, 1 = byte access.
REQ-005 The block SHALL expose input MEM_ALUResult, 32 bits: effective byte address.
REQ-006 The block SHALL expose input MEM_Data2, 32 bits: store data.
REQ-007 The block SHALL expose inputs MEM_Branch and MEM_Zero, 1 bit each; MEM_PCResult, MEM_jumpImm and MEM_jumpRs, 32 bits each; Jump_out, 2 bits.
REQ-008 The block SHALL expose outputs dmem_req, dmem_we (1 bit), dmem_addr and dmem_wdata (32 bits), dmem_be (4 bits); and inputs dmem_ack (1 bit) and dmem_rdata (32 bits).
REQ-009 The block SHALL expose outputs MemStall, ReadValid, AlignErr, BusErr and PCSrc (1 bit each), and ReadData and PCTarget (32 bits each).

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS and DONE.
REQ-011 In IDLE with (MEM_MemRead|MEM_MemWrite)=1 and aligned, the FSM SHALL drive dmem_req=1 combinationally, assert MemStall, and go to ACCESS.
REQ-012 Alignment: a word access SHALL be misaligned when addr[1:0]!=0; a byte access is always aligned.
REQ-013 A misaligned access SHALL pulse AlignErr for 1 cycle, issue no request, raise no MemStall, and leave the FSM in IDLE.
REQ-014 In ACCESS, dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL be held stable from registered copies, and MemStall SHALL be 1.
REQ-015 In ACCESS, dmem_ack=1 SHALL capture the read data and move the FSM to DONE.
REQ-016 An 8-bit timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; at count 255 without ack it SHALL set BusErr, force ReadData=0, and go to DONE.
REQ-017 If ack arrives in the cycle the count reaches 255, ack SHALL win and BusErr SHALL stay 0.
REQ-018 DONE SHALL last exactly 1 cycle with MemStall=0, ReadValid=1 for loads, and BusErr held if set; the FSM then returns to IDLE unconditionally and no request is issued in DONE.
REQ-019 Min latency for an ack in the first ACCESS cycle SHALL be: request cycle, ACCESS, DONE = 3 cycles, with 2 stall cycles.
REQ-020 Word accesses SHALL use dmem_be=4'b1111, a word-aligned dmem_addr, and dmem_wdata=MEM_Data2.
REQ-021 Byte accesses SHALL use lane addr[1:0], little-endian: dmem_be=1<<lane, with store byte MEM_Data2[7:0] replicated to all lanes.
REQ-022 A byte load SHALL sign-extend the selected lane; dmem_addr SHALL be {addr[31:2],2'b00} in all cases.
REQ-023 dmem_we SHALL be 1 for stores; MEM_MemRead and MEM_MemWrite both 1 SHALL be treated as a store.
REQ-024 Redirect priority SHALL be: Jump_out=01 gives PCTarget=MEM_jumpImm; 10 gives MEM_jumpRs; else Branch&Zero gives MEM_PCResult. Jump_out=11 is reserved, no jump.
REQ-025 PCSrc SHALL be 1 when any redirect is selected and MemStall=0; combinational.

Reset
REQ-026 Rst_n=0 SHALL immediately force state IDLE and set dmem_req, dmem_we, dmem_be, MemStall, ReadValid, AlignErr, BusErr, PCSrc, ReadData, counter and the registered address/data to 0.
REQ-027 Reset mid-ACCESS SHALL abandon the transaction; a late dmem_ack in IDLE SHALL be ignored.

Structure
REQ-028 Shared package mem_pkg SHALL hold the state enum, the DT_WORD/DT_BYTE encodings, the JMP_IMM/JMP_RS encodings, and TIMEOUT_MAX=255.
REQ-029 A single sub-module, mem_byte_align, SHALL contain the combinational be/wdata generation and the load lane extract/sign-extend logic.

Verification
REQ-030 Word load at 0x100, ack on the 1st ACCESS cycle, rdata 0xDEADBEEF -> MemStall for 2 cycles, ReadValid with ReadData=0xDEADBEEF in DONE.
REQ-031 Byte store at 0x203 with Data2=0x000000A5 -> dmem_be=4'b1000, wdata=0xA5A5A5A5, addr=0x200, we=1.
REQ-032 Byte load at 0x201 with rdata 0x00008000 -> ReadData=0xFFFFFF80.
REQ-033 Word load at 0x102 -> AlignErr pulse, dmem_req never 1, MemStall=0.
REQ-034 No ack for 255 cycles -> BusErr=1 and ReadData=0 in DONE; a second run with ack at count 255 -> BusErr=0.
REQ-035 Rst_n low during ACCESS, then ack 1 cycle later -> IDLE, no ReadValid, outputs 0; Jump_out=10 with jumpRs=0x400 -> PCSrc=1, PCTarget=0x400.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and encodings for the MEM-stage data-memory controller.
// Latency: none (declarations only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  localparam logic       DT_WORD     = 1'b0;
  localparam logic       DT_BYTE     = 1'b1;
  localparam logic [1:0] JMP_IMM     = 2'b01;
  localparam logic [1:0] JMP_RS      = 2'b10;
  localparam logic [7:0] TIMEOUT_MAX = 8'd255;

  // Byte accesses can land on any lane; words must sit on a 4-byte boundary.
  function automatic logic is_aligned(input logic dt, input logic [1:0] lane);
    return (dt == DT_BYTE) || (lane == 2'b00);
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering: store byte enables / data replication and load lane extract.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module mem_byte_align
  import mem_pkg::*;
(
  input  logic        datatype,
  input  logic [1:0]  lane,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0] lane_byte;

  assign lane_byte = rdata[{lane, 3'b000} +: 8];

  // Word accesses pass straight through; byte accesses use little-endian lanes.
  always_comb begin
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = rdata;
    if (datatype == DT_BYTE) begin
      be      = 4'b0001 << lane;
      wdata   = {4{st_data[7:0]}};
      ld_data = {{24{lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage load/store sequencer with alignment check, bus timeout and PC redirect select.
// Latency: request cycle + >=1 ACCESS cycle + 1 DONE cycle (3 cycles minimum, 2 stalled).
// Backpressure: holds the pipeline with MemStall until dmem_ack or a 256-cycle timeout.
module mem_stage_ctrl
  import mem_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_Datatype,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_Data2,
  input  logic        MEM_Branch,
  input  logic        MEM_Zero,
  input  logic [31:0] MEM_PCResult,
  input  logic [31:0] MEM_jumpImm,
  input  logic [31:0] MEM_jumpRs,
  input  logic [1:0]  Jump_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MemStall,
  output logic        ReadValid,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        PCSrc,
  output logic [31:0] ReadData,
  output logic [31:0] PCTarget
);

  mem_state_t  state;
  logic [7:0]  tmo_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        dt_q;
  logic [1:0]  lane_q;
  logic        is_load_q;

  logic        mem_access;
  logic        aligned;
  logic        start;
  logic        in_access;
  logic        dt_sel;
  logic [1:0]  lane_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld_data;
  logic        redirect;

  assign mem_access = MEM_MemRead | MEM_MemWrite;
  assign aligned    = is_aligned(MEM_Datatype, MEM_ALUResult[1:0]);
  assign in_access  = (state == ST_ACCESS);
  assign start      = Rst_n & (state == ST_IDLE) & mem_access & aligned;

  // While waiting for ack the lane decode must come from the captured request,
  // since the load data is extracted in the ack cycle.
  assign dt_sel   = in_access ? dt_q : MEM_Datatype;
  assign lane_sel = in_access ? lane_q : MEM_ALUResult[1:0];

  mem_byte_align u_align (
    .datatype (dt_sel),
    .lane     (lane_sel),
    .st_data  (MEM_Data2),
    .rdata    (dmem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data)
  );

  // Memory port: live decode in the launch cycle, registered copies while waiting.
  always_comb begin
    dmem_req   = start | in_access;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_be    = 4'h0;
    if (in_access) begin
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
      dmem_be    = be_q;
    end else if (start) begin
      dmem_we    = MEM_MemWrite;
      dmem_addr  = {MEM_ALUResult[31:2], 2'b00};
      dmem_wdata = al_wdata;
      dmem_be    = al_be;
    end
  end

  assign MemStall = dmem_req;
  assign AlignErr = Rst_n & (state == ST_IDLE) & mem_access & ~aligned;

  // Redirect select: explicit jumps first, then taken branch; 2'b11 is not a jump.
  always_comb begin
    redirect = 1'b1;
    PCTarget = MEM_PCResult;
    if (Jump_out == JMP_IMM) begin
      PCTarget = MEM_jumpImm;
    end else if (Jump_out == JMP_RS) begin
      PCTarget = MEM_jumpRs;
    end else if (!(MEM_Branch & MEM_Zero)) begin
      redirect = 1'b0;
      PCTarget = 32'h0;
    end
  end

  assign PCSrc = Rst_n & redirect & ~MemStall;

  // Access sequencer: capture request, wait for ack or timeout, one DONE cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      tmo_cnt   <= 8'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      we_q      <= 1'b0;
      dt_q      <= DT_WORD;
      lane_q    <= 2'b00;
      is_load_q <= 1'b0;
      ReadValid <= 1'b0;
      BusErr    <= 1'b0;
      ReadData  <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          ReadValid <= 1'b0;
          BusErr    <= 1'b0;
          if (start) begin
            state     <= ST_ACCESS;
            tmo_cnt   <= 8'd0;
            addr_q    <= {MEM_ALUResult[31:2], 2'b00};
            wdata_q   <= al_wdata;
            be_q      <= al_be;
            we_q      <= MEM_MemWrite;
            dt_q      <= MEM_Datatype;
            lane_q    <= MEM_ALUResult[1:0];
            is_load_q <= ~MEM_MemWrite;
          end
        end
        ST_ACCESS: begin
          if (dmem_ack) begin
            // An ack in the final timeout cycle still counts as success.
            state     <= ST_DONE;
            ReadData  <= al_ld_data;
            ReadValid <= is_load_q;
            BusErr    <= 1'b0;
          end else if (tmo_cnt == TIMEOUT_MAX) begin
            state     <= ST_DONE;
            ReadData  <= 32'h0;
            ReadValid <= is_load_q;
            BusErr    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ReadValid <= 1'b0;
          BusErr    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: scoreboarded loads, store lane checks, timeout, reset, redirect.
// Latency: checks request/ACCESS/DONE sequencing cycle by cycle.
// Backpressure: ack timing is driven per transaction; stall length is checked.
module tb_mem_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        MEM_MemRead, MEM_MemWrite, MEM_Datatype;
  logic [31:0] MEM_ALUResult, MEM_Data2;
  logic        MEM_Branch, MEM_Zero;
  logic [31:0] MEM_PCResult, MEM_jumpImm, MEM_jumpRs;
  logic [1:0]  Jump_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        MemStall, ReadValid, AlignErr, BusErr, PCSrc;
  logic [31:0] ReadData, PCTarget;

  typedef struct {
    logic [31:0] data;
    logic        berr;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  mem_stage_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_Datatype(MEM_Datatype),
    .MEM_ALUResult(MEM_ALUResult), .MEM_Data2(MEM_Data2),
    .MEM_Branch(MEM_Branch), .MEM_Zero(MEM_Zero), .MEM_PCResult(MEM_PCResult),
    .MEM_jumpImm(MEM_jumpImm), .MEM_jumpRs(MEM_jumpRs), .Jump_out(Jump_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MemStall(MemStall), .ReadValid(ReadValid), .AlignErr(AlignErr), .BusErr(BusErr),
    .PCSrc(PCSrc), .ReadData(ReadData), .PCTarget(PCTarget)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every ReadValid must match the oldest pending load.
  always @(negedge Clk) begin
    if (ReadValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rv_unexpected", 32'(ReadValid), 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("rdata", ReadData, e.data);
        check("rv_berr", 32'(BusErr), 32'(e.berr));
      end
    end
  end

  // Called and returns just after a rising edge with the FSM idle.
  task automatic mem_txn(input logic rd, input logic wr, input logic dt,
                         input logic [31:0] addr, input logic [31:0] data2,
                         input int ack_at, input logic [31:0] rdata,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_berr,
                         input int exp_stalls);
    int   stalls;
    logic held_ok;
    sb_t  e;
    MEM_MemRead   = rd;
    MEM_MemWrite  = wr;
    MEM_Datatype  = dt;
    MEM_ALUResult = addr;
    MEM_Data2     = data2;
    MEM_Branch    = 1'b1;
    MEM_Zero      = 1'b1;
    dmem_rdata    = rdata;
    @(negedge Clk);
    check("req", 32'(dmem_req), 32'd1);
    check("stall_req", 32'(MemStall), 32'd1);
    check("we", 32'(dmem_we), 32'(exp_we));
    check("addr", dmem_addr, exp_addr);
    check("be", 32'(dmem_be), 32'(exp_be));
    check("wdata", dmem_wdata, exp_wdata);
    check("pcsrc_stalled", 32'(PCSrc), 32'd0);
    if (rd && !wr) begin
      e.data = exp_rdata;
      e.berr = exp_berr;
      sb.push_back(e);
    end
    stalls  = 1;
    held_ok = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge Clk); #1;
      dmem_ack      = (k == ack_at);
      MEM_ALUResult = ~addr;
      MEM_Data2     = ~data2;
      @(negedge Clk);
      if (!MemStall) break;
      stalls++;
      if (dmem_req !== 1'b1 || dmem_addr !== exp_addr || dmem_be !== exp_be ||
          dmem_wdata !== exp_wdata || dmem_we !== exp_we) held_ok = 1'b0;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("held_stable", 32'(held_ok), 32'd1);
    check("req_done", 32'(dmem_req), 32'd0);
    check("berr_done", 32'(BusErr), 32'(exp_berr));
    check("rvalid_done", 32'(ReadValid), 32'(rd && !wr));
    check("pcsrc_done", 32'(PCSrc), 32'd1);
    @(posedge Clk); #1;
    MEM_MemRead  = 1'b0;
    MEM_MemWrite = 1'b0;
    MEM_Branch   = 1'b0;
    MEM_Zero     = 1'b0;
    dmem_ack     = 1'b0;
    @(negedge Clk);
    check("rvalid_clr", 32'(ReadValid), 32'd0);
    check("berr_clr", 32'(BusErr), 32'd0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  j_sel [5];
    logic        j_br  [5];
    logic        j_z   [5];
    logic [31:0] j_tgt [5];
    logic        j_src [5];

    Rst_n = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_Datatype = 1'b0;
    MEM_ALUResult = 32'h0; MEM_Data2 = 32'h0;
    MEM_Branch = 1'b0; MEM_Zero = 1'b0;
    MEM_PCResult = 32'h0000_0800; MEM_jumpImm = 32'h0000_0123; MEM_jumpRs = 32'h0000_0400;
    Jump_out = 2'b00; dmem_ack = 1'b0; dmem_rdata = 32'h0;

    @(negedge Clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(MemStall), 32'd0);
    check("rst_rvalid", 32'(ReadValid), 32'd0);
    check("rst_rdata", ReadData, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // rd wr dt addr data2 ack rdata | we addr be wdata exp_rdata berr stalls
    mem_txn(1, 0, 0, 32'h100, 32'h1122_3344, 0, 32'hDEAD_BEEF,
            0, 32'h100, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF, 0, 2);
    mem_txn(0, 1, 1, 32'h203, 32'h0000_00A5, 2, 32'h0,
            1, 32'h200, 4'b1000, 32'hA5A5_A5A5, 32'h0, 0, 4);
    mem_txn(1, 0, 1, 32'h201, 32'h0, 1, 32'h0000_8000,
            0, 32'h200, 4'b0010, 32'h0000_0000, 32'hFFFF_FF80, 0, 3);
    mem_txn(1, 0, 1, 32'h202, 32'h0000_0011, 0, 32'h0045_0000,
            0, 32'h200, 4'b0100, 32'h1111_1111, 32'h0000_0045, 0, 2);
    mem_txn(1, 1, 0, 32'h10C, 32'hCAFE_F00D, 0, 32'h0,
            1, 32'h10C, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 2);
    mem_txn(1, 0, 0, 32'h400, 32'h0, -1, 32'h5555_5555,
            0, 32'h400, 4'b1111, 32'h0, 32'h0, 1, 257);
    mem_txn(1, 0, 0, 32'h404, 32'h0, 255, 32'h1234_5678,
            0, 32'h404, 4'b1111, 32'h0, 32'h1234_5678, 0, 257);

    // Misaligned word load.
    MEM_MemRead = 1'b1; MEM_Datatype = 1'b0; MEM_ALUResult = 32'h102;
    @(negedge Clk);
    check("align_err", 32'(AlignErr), 32'd1);
    check("align_req", 32'(dmem_req), 32'd0);
    check("align_stall", 32'(MemStall), 32'd0);
    @(posedge Clk); #1;
    MEM_MemRead = 1'b0;
    @(negedge Clk);
    check("align_clr", 32'(AlignErr), 32'd0);
    check("align_idle_req", 32'(dmem_req), 32'd0);
    @(posedge Clk); #1;

    // Reset in the middle of an access, then a stale ack.
    MEM_MemRead = 1'b1; MEM_Datatype = 1'b0; MEM_ALUResult = 32'h300;
    @(negedge Clk);
    check("rst_txn_req", 32'(dmem_req), 32'd1);
    @(posedge Clk); #1;
    #2;
    Rst_n = 1'b0;
    MEM_MemRead = 1'b0;
    #1;
    check("arst_req", 32'(dmem_req), 32'd0);
    check("arst_stall", 32'(MemStall), 32'd0);
    check("arst_be", 32'(dmem_be), 32'd0);
    check("arst_we", 32'(dmem_we), 32'd0);
    check("arst_rdata", ReadData, 32'h0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000_0BAD;
    @(negedge Clk);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_rv", 32'(ReadValid), 32'd0);
    @(posedge Clk); #1;
    dmem_ack = 1'b0;
    @(negedge Clk);
    check("late_ack_rv2", 32'(ReadValid), 32'd0);
    check("late_ack_rdata", ReadData, 32'h0);
    @(posedge Clk); #1;

    // Redirect selection table.
    j_sel = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
    j_br  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    j_z   = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    j_tgt = '{32'h400, 32'h123, 32'h800, 32'h0, 32'h0};
    j_src = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 5; i++) begin
      Jump_out = j_sel[i];
      MEM_Branch = j_br[i];
      MEM_Zero = j_z[i];
      @(negedge Clk);
      check("pcsrc", 32'(PCSrc), 32'(j_src[i]));
      if (j_src[i]) check("pctarget", PCTarget, j_tgt[i]);
      @(posedge Clk); #1;
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
